mul_acc_int: RTL

- Iterative radix-2 shift-add multiply-accumulate unit. Computes {hi,lo} = a*b + c.
- It is the inverse companion of the iterative divider: it rebuilds a dividend from quotient, divisor and remainder (x = q*y + r).
- It also serves the ALU's multi-cycle `*`, `*/` and `UM*` paths, so the large combinational multiplier can be removed from the timing-critical path.
- It sits beside the divider in the ALU extension group and uses the same start/busy style.

---
 rtl/mul_acc_int.sv | 113 +++++++++++
 1 files changed

// File: rtl/mul_acc_int.sv
// Iterative radix-2 shift-add multiply-accumulate: {hi,lo} = a*b + c in DSZ+1 clocks.
// Companion of the iterative divider; shares its start/busy handshake.
module mul_acc_int #(
   parameter int DSZ = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           sgn,
   input  logic [DSZ-1:0] a,
   input  logic [DSZ-1:0] b,
   input  logic [DSZ-1:0] c,
   output logic           busy,
   output logic           done,
   output logic [DSZ-1:0] hi,
   output logic [DSZ-1:0] lo
);

   localparam int CW = $clog2(DSZ);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [2*DSZ-1:0]   r_mcand;
   logic [DSZ-1:0]     r_mplier;
   logic [2*DSZ-1:0]   r_acc;
   logic [2*DSZ-1:0]   r_cext;
   logic               r_neg;
   logic [CW-1:0]      r_cnt;
   logic               r_done;
   logic [DSZ-1:0]     r_hi;
   logic [DSZ-1:0]     r_lo;

   logic [DSZ-1:0]     w_abs_a;
   logic [DSZ-1:0]     w_abs_b;
   logic [2*DSZ-1:0]   w_cext;
   logic [2*DSZ-1:0]   w_res;

   // The most negative operand negates to itself, which is its correct unsigned magnitude.
   assign w_abs_a = (sgn & a[DSZ-1]) ? -a : a;
   assign w_abs_b = (sgn & b[DSZ-1]) ? -b : b;
   assign w_cext  = {{DSZ{sgn & c[DSZ-1]}}, c};
   assign w_res   = (r_neg ? -r_acc : r_acc) + r_cext;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values, independent of the order the statements appear in.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // NOTE: default first, so every path assigns w_state_nxt and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (r_cnt == CW'(DSZ-1)) w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != S_IDLE);
      done = r_done;
      hi   = r_hi;
      lo   = r_lo;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cext   <= '0;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_done <= (r_state == S_FIX);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mcand  <= {{DSZ{1'b0}}, w_abs_a};
                  r_mplier <= w_abs_b;
                  r_neg    <= sgn & (a[DSZ-1] ^ b[DSZ-1]);
                  r_cext   <= w_cext;
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end
            end
            S_RUN: begin
               if (r_mplier[0]) r_acc <= r_acc + r_mcand;
               r_mplier <= r_mplier >> 1;
               r_mcand  <= r_mcand << 1;
               r_cnt    <= r_cnt + 1'b1;
            end
            S_FIX: begin
               {r_hi, r_lo} <= w_res;
            end
            default: ;
         endcase
      end
   end

endmodule
